// File: rtl/pci_target_mem.sv
// rtl/pci_target_mem.sv - PCI memory target serving read/write bursts from a register-file window
module pci_target_mem #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          ADDR_BITS   = 4,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_n,
   input  logic        irdy_n,
   input  logic [3:0]  cbe_n,
   inout  wire  [31:0] ad,
   output logic        devsel_n,
   output logic        trdy_n,
   output logic        stop_n
);
   localparam int                   DEPTH = 2**ADDR_BITS;
   localparam logic [2:0]           WS    = 3'(WAIT_STATES);
   localparam logic [ADDR_BITS-1:0] LAST  = ADDR_BITS'(DEPTH-1);

   typedef enum logic [2:0] {IDLE, W_DATA, R_TA, R_DATA, DISC, TURN} state_t;

   state_t                     state_q, state_d;
   logic [ADDR_BITS-1:0]       addr_q, addr_d;
   logic [2:0]                 wait_q, wait_d;
   logic                       is_rd_q, is_rd_d;
   logic [DEPTH-1:0][31:0]     mem_q;

   logic        in_data, xfer, hit, ad_oe;
   logic [31:0] rd_data, wr_word;

   assign in_data  = (state_q == W_DATA) || (state_q == R_DATA);
   assign trdy_n   = !(in_data && (wait_q == WS));
   assign devsel_n = !(in_data || (state_q == R_TA) || (state_q == DISC));
   assign stop_n   = (state_q != DISC);
   assign xfer     = in_data && !irdy_n && !trdy_n;

   // Claim only aligned memory read (0110) / write (0111) cycles inside the window.
   assign hit = (ad[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]) &&
                (ad[1:0] == 2'b00) && (cbe_n[3:1] == 3'b011);

   assign rd_data = mem_q[addr_q];
   assign ad_oe   = (state_q == R_DATA) || ((state_q == DISC) && is_rd_q);
   assign ad      = ad_oe ? rd_data : 'z;

   always_comb begin
      wr_word = rd_data;
      for (int b = 0; b < 4; b++) begin
         if (!cbe_n[b]) wr_word[8*b +: 8] = ad[8*b +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wait_d  = '0;
      is_rd_d = is_rd_q;
      case (state_q)
         IDLE: begin
            if (!frame_n && hit) begin
               addr_d  = ad[ADDR_BITS+1:2];
               is_rd_d = !cbe_n[0];
               state_d = cbe_n[0] ? W_DATA : R_TA;
            end
         end
         W_DATA, R_DATA: begin
            if (xfer) begin
               // The window top never wraps; a continuing burst is stopped instead.
               if (addr_q != LAST) addr_d = addr_q + 1'b1;
               if (frame_n)               state_d = TURN;
               else if (addr_q == LAST)   state_d = DISC;
            end else if (frame_n && irdy_n) begin
               state_d = TURN;
            end else begin
               wait_d = (wait_q == WS) ? wait_q : wait_q + 3'd1;
            end
         end
         R_TA:    state_d = R_DATA;
         DISC:    if (frame_n) state_d = TURN;
         TURN:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wait_q  <= '0;
         is_rd_q <= 1'b0;
         mem_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wait_q  <= wait_d;
         is_rd_q <= is_rd_d;
         if (xfer && (state_q == W_DATA)) mem_q[addr_q] <= wr_word;
      end
   end
endmodule

// File: tb/tb_pci_target_mem.sv
// tb/tb_pci_target_mem.sv - scoreboard bench for pci_target_mem (WAIT_STATES 0 and 2 instances)
module tb_pci_target_mem;
   logic        clk = 1'b0;
   logic        rst;
   logic        frame_n, irdy_n;
   logic [3:0]  cbe_n;
   logic        tb_oe;
   logic [31:0] tb_ad;
   wire  [31:0] ad0, ad2;
   logic        devsel0, trdy0, stop0, devsel2, trdy2, stop2;
   bit          sel;

   always #5 clk = ~clk;

   assign ad0 = tb_oe ? tb_ad : 'z;
   assign ad2 = tb_oe ? tb_ad : 'z;

   pci_target_mem #(.WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .cbe_n(cbe_n),
      .ad(ad0), .devsel_n(devsel0), .trdy_n(trdy0), .stop_n(stop0));

   pci_target_mem #(.WAIT_STATES(2)) u_dut2 (
      .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .cbe_n(cbe_n),
      .ad(ad2), .devsel_n(devsel2), .trdy_n(trdy2), .stop_n(stop2));

   wire        o_devsel = sel ? devsel2 : devsel0;
   wire        o_trdy   = sel ? trdy2   : trdy0;
   wire        o_stop   = sel ? stop2   : stop0;
   wire [31:0] o_ad     = sel ? ad2     : ad0;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   int          edges_q[$];
   logic [31:0] wq[$];
   logic [3:0]  beq[$];
   int          stall_phase  = -1;
   int          stall_cycles = 0;
   bit          hold_frame   = 1'b0;
   int          abort_after  = -1;

   task automatic bus_idle();
      frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'hF; tb_oe = 1'b0; tb_ad = '0;
   endtask

   // Master model: address phase, then data phases paced by the selected DUT's TRDY#.
   task automatic run_txn(input bit wr, input logic [31:0] a, input int n);
      int          done, e, stall_left;
      bit          xf, setup;
      logic [31:0] exp;
      done = 0; e = 0; stall_left = 0; setup = 1'b1;
      edges_q.delete();
      @(posedge clk); #1;
      frame_n = 1'b0; irdy_n = 1'b1; cbe_n = wr ? 4'b0111 : 4'b0110; tb_oe = 1'b1; tb_ad = a;
      @(posedge clk); #1;
      while (done < n) begin
         if (setup) begin
            setup      = 1'b0;
            stall_left = (done == stall_phase) ? stall_cycles : 0;
            irdy_n     = (stall_left > 0);
            frame_n    = (done == n-1) && !hold_frame && !irdy_n;
            if (wr) begin tb_oe = 1'b1; tb_ad = wq[done]; cbe_n = beq[done]; end
            else    begin tb_oe = 1'b0; cbe_n = 4'h0; end
         end
         @(negedge clk);
         if (e == 0) begin
            n_checks++;
            if (o_devsel !== 1'b0) begin n_fail++; $display("FAIL claim: devsel_n=%b expected 0", o_devsel); end
         end
         n_checks++;
         if (!o_trdy && !o_stop) begin n_fail++; $display("FAIL trdy_stop_overlap: trdy_n=%b stop_n=%b", o_trdy, o_stop); end
         xf = !irdy_n && !o_trdy;
         if (xf && !wr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rd_extra: got %h expected no transfer", o_ad);
            end else begin
               exp = exp_q.pop_front();
               if (o_ad !== exp) begin n_fail++; $display("FAIL rd_data: got %h expected %h", o_ad, exp); end
            end
         end
         @(posedge clk); #1;
         e++;
         if (xf) begin
            edges_q.push_back(e);
            done++;
            setup = (done < n);
            if (done == abort_after) begin
               @(negedge clk); #2;
               rst = 1'b0;
               #1;
               n_checks++;
               if ({o_devsel, o_trdy, o_stop} !== 3'b111) begin
                  n_fail++; $display("FAIL async_reset: devsel/trdy/stop=%b expected 111", {o_devsel, o_trdy, o_stop});
               end
               bus_idle(); tb_oe = 1'b1;
               #1;
               n_checks++;
               if (o_ad !== 32'h0) begin n_fail++; $display("FAIL reset_ad_release: got %h expected 00000000", o_ad); end
               tb_oe = 1'b0;
               @(negedge clk); rst = 1'b1;
               exp_q.delete();
               return;
            end
            if (done == n) begin
               irdy_n = 1'b1; tb_oe = 1'b0; cbe_n = 4'hF;
               if (!hold_frame) frame_n = 1'b1;
            end
         end else if (stall_left > 0) begin
            stall_left--;
            irdy_n  = (stall_left > 0);
            frame_n = (done == n-1) && !hold_frame && !irdy_n;
         end
         if (e > 60) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: %0d of %0d transfers after %0d edges", done, n, e);
            bus_idle();
            return;
         end
      end
      if (!hold_frame) begin
         @(negedge clk);
         n_checks++;
         if ({o_devsel, o_trdy} !== 2'b11) begin
            n_fail++; $display("FAIL devsel_release: devsel/trdy=%b expected 11", {o_devsel, o_trdy});
         end
      end
   endtask

   task automatic test_reset();
      bus_idle();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({devsel0, trdy0, stop0, devsel2, trdy2, stop2} !== 6'b111111) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected 111111", {devsel0, trdy0, stop0, devsel2, trdy2, stop2});
      end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_single();
      wq = '{32'hDEADBEEF}; beq = '{4'h0};
      run_txn(1'b1, 32'h1000_0008, 1);
      n_checks++;
      if (edges_q.size() != 1 || edges_q[0] != 1) begin n_fail++; $display("FAIL wr_latency: got %p expected 1", edges_q); end
      exp_q.push_back(32'hDEADBEEF);
      run_txn(1'b0, 32'h1000_0008, 1);
      n_checks++;
      if (edges_q.size() != 1 || edges_q[0] != 2) begin n_fail++; $display("FAIL rd_latency: got %p expected 2", edges_q); end
   endtask

   task automatic test_byte_enables();
      wq = '{32'h11223344}; beq = '{4'h0};
      run_txn(1'b1, 32'h1000_0004, 1);
      wq = '{32'hAABBCCDD}; beq = '{4'b1010};
      run_txn(1'b1, 32'h1000_0004, 1);
      exp_q.push_back(32'h11BB33DD);
      run_txn(1'b0, 32'h1000_0004, 1);
   endtask

   task automatic test_burst();
      wq = '{32'd1, 32'd2, 32'd3, 32'd4}; beq = '{4'h0, 4'h0, 4'h0, 4'h0};
      stall_phase = 2; stall_cycles = 2;
      run_txn(1'b1, 32'h1000_0000, 4);
      n_checks++;
      if (edges_q.size() != 4 || edges_q[3] != 6) begin n_fail++; $display("FAIL burst_stall_edges: got %p expected last 6", edges_q); end
      stall_phase = -1; stall_cycles = 0;
      for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
      run_txn(1'b0, 32'h1000_0000, 4);
      n_checks++;
      if (edges_q.size() != 4 || edges_q[0] != 2 || edges_q[3] != 5) begin
         n_fail++; $display("FAIL burst_rd_edges: got %p expected 2..5", edges_q);
      end
   endtask

   task automatic test_disconnect();
      logic [3:0] got;
      wq = '{32'hE0E0_000E, 32'hF0F0_000F}; beq = '{4'h0, 4'h0};
      run_txn(1'b1, 32'h1000_0038, 2);
      exp_q.push_back(32'hE0E0_000E); exp_q.push_back(32'hF0F0_000F);
      hold_frame = 1'b1;
      run_txn(1'b0, 32'h1000_0038, 2);
      hold_frame = 1'b0;
      n_checks++;
      if (edges_q.size() != 2 || edges_q[1] != 3) begin n_fail++; $display("FAIL disc_edges: got %p expected 2,3", edges_q); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         got = {o_devsel, o_trdy, o_stop, 1'b0};
         n_checks++;
         if (got !== 4'b0100 || o_ad !== 32'hF0F0_000F) begin
            n_fail++; $display("FAIL disc_hold: devsel/trdy/stop=%b ad=%h expected 010 f0f0000f", got[3:1], o_ad);
         end
         if (i == 1) begin @(posedge clk); #1; frame_n = 1'b1; end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if ({o_devsel, o_trdy, o_stop} !== 3'b111) begin
            n_fail++; $display("FAIL disc_turn: devsel/trdy/stop=%b expected 111", {o_devsel, o_trdy, o_stop});
         end
      end
   endtask

   task automatic test_decode_miss();
      logic [31:0] addrs[4];
      logic [3:0]  cmds[4];
      addrs = '{32'h2000_0000, 32'h1000_0000, 32'h1000_0001, 32'h1000_0040};
      cmds  = '{4'b0110, 4'b0010, 4'b0110, 4'b0111};
      for (int t = 0; t < 4; t++) begin
         @(posedge clk); #1;
         frame_n = 1'b0; irdy_n = 1'b1; cbe_n = cmds[t]; tb_oe = 1'b1; tb_ad = addrs[t];
         @(posedge clk); #1;
         frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'h0; tb_ad = '0;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (o_devsel !== 1'b1 || o_ad !== 32'h0) begin
               n_fail++; $display("FAIL decode_miss_%0d: devsel_n=%b ad=%h expected 1 00000000", t, o_devsel, o_ad);
            end
         end
         bus_idle();
      end
   endtask

   task automatic test_back_to_back();
      wq = '{32'h0000_C0DE}; beq = '{4'h0};
      run_txn(1'b1, 32'h1000_000C, 1);
      frame_n = 1'b0; cbe_n = 4'b0110; tb_oe = 1'b1; tb_ad = 32'h1000_000C;
      @(posedge clk); #1;
      bus_idle();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++;
         if (o_devsel !== 1'b1) begin n_fail++; $display("FAIL turn_no_claim: devsel_n=%b expected 1", o_devsel); end
      end
      exp_q.push_back(32'h0000_C0DE);
      run_txn(1'b0, 32'h1000_000C, 1);
   endtask

   task automatic test_wait_states();
      sel = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      wq = '{32'hA1, 32'hA2, 32'hA3}; beq = '{4'h0, 4'h0, 4'h0};
      run_txn(1'b1, 32'h1000_0010, 3);
      n_checks++;
      if (edges_q.size() != 3 || edges_q[0] != 3 || edges_q[2] != 9) begin
         n_fail++; $display("FAIL ws_wr_edges: got %p expected 3,6,9", edges_q);
      end
      exp_q.push_back(32'hA1); exp_q.push_back(32'hA2); exp_q.push_back(32'hA3);
      run_txn(1'b0, 32'h1000_0010, 3);
      n_checks++;
      if (edges_q.size() != 3 || edges_q[0] != 4) begin n_fail++; $display("FAIL ws_rd_first: got %p expected 4", edges_q); end
      for (int i = 1; i < edges_q.size(); i++) begin
         n_checks++;
         if (edges_q[i] - edges_q[i-1] != 3) begin
            n_fail++; $display("FAIL ws_rd_spacing: got %0d expected 3", edges_q[i] - edges_q[i-1]);
         end
      end
      exp_q.push_back(32'hA1); exp_q.push_back(32'hA2); exp_q.push_back(32'hA3);
      abort_after = 2;
      run_txn(1'b0, 32'h1000_0010, 3);
      abort_after = -1;
      exp_q.push_back(32'h0);
      run_txn(1'b0, 32'h1000_0010, 1);
   endtask

   initial begin
      sel = 1'b0;
      test_reset();
      test_single();
      test_byte_enables();
      test_burst();
      test_disconnect();
      test_decode_miss();
      test_back_to_back();
      test_wait_states();
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d reads never observed", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
